// File: rtl/apb_master_bridge_if.sv
// Command, response and APB3 signals of apb_master_bridge in one bundle.
// The master modport is the bridge side. The slave modport is the controller/APB side.
interface apb_master_bridge_if #(
   parameter int ADDR_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [31:0]       cmd_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;

   logic [ADDR_W-1:0] APB_M_0_paddr;
   logic              APB_M_0_psel;
   logic              APB_M_0_penable;
   logic              APB_M_0_pwrite;
   logic [31:0]       APB_M_0_pwdata;
   logic [31:0]       APB_M_0_prdata;
   logic              APB_M_0_pready;
   logic              APB_M_0_pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
             APB_M_0_prdata, APB_M_0_pready, APB_M_0_pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             APB_M_0_paddr, APB_M_0_psel, APB_M_0_penable, APB_M_0_pwrite, APB_M_0_pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
             APB_M_0_prdata, APB_M_0_pready, APB_M_0_pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             APB_M_0_paddr, APB_M_0_psel, APB_M_0_penable, APB_M_0_pwrite, APB_M_0_pwdata
   );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator. Accept-to-rsp_valid latency is 3 + wait states (TIMEOUT + 2 on timeout).
// Response backpressure holds RESP, with cmd_ready low, until rsp_ready.
module apb_master_bridge #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input logic                 APB_0_axiclk,
   input logic                 APB_0_reset,
   apb_master_bridge_if.master bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]        state;
   logic [7:0]        wait_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;
   logic              timeout_q;

   always_ff @(posedge APB_0_axiclk) begin
      if (APB_0_reset) begin
         state     <= IDLE;
         wait_cnt  <= 8'd0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= 32'd0;
         rdata_q   <= 32'd0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  addr_q  <= bus.cmd_addr;
                  write_q <= bus.cmd_write;
                  wdata_q <= bus.cmd_wdata;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               wait_cnt <= 8'd0;
               state    <= ACCESS;
            end
            ACCESS: begin
               // pready wins over the timeout on the last allowed cycle.
               if (bus.APB_M_0_pready) begin
                  rdata_q   <= write_q ? 32'd0 : bus.APB_M_0_prdata;
                  err_q     <= bus.APB_M_0_pslverr;
                  timeout_q <= 1'b0;
                  state     <= RESP;
               end else if (wait_cnt == WAIT_LAST) begin
                  rdata_q   <= 32'd0;
                  err_q     <= 1'b1;
                  timeout_q <= 1'b1;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stale pready/pslverr outside ACCESS never reach any state above.
   assign bus.cmd_ready       = (state == IDLE);
   assign bus.rsp_valid       = (state == RESP);
   assign bus.rsp_rdata       = rdata_q;
   assign bus.rsp_err         = err_q;
   assign bus.rsp_timeout     = timeout_q;
   assign bus.APB_M_0_psel    = (state == SETUP) || (state == ACCESS);
   assign bus.APB_M_0_penable = (state == ACCESS);
   assign bus.APB_M_0_paddr   = addr_q;
   assign bus.APB_M_0_pwrite  = write_q;
   assign bus.APB_M_0_pwdata  = wdata_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge.
// A configurable APB slave is checked against a transaction-level latency/response model.
module tb_apb_master_bridge;
   localparam int TMO = 16;

   logic clk;
   logic rst;
   int   errs   = 0;
   int   checks = 0;

   apb_master_bridge_if #(.ADDR_W(32)) bus ();

   apb_master_bridge #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
      .APB_0_axiclk (clk),
      .APB_0_reset  (rst),
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Slave: ready after s_wait ACCESS cycles; pready lingers s_linger cycles after completion.
   int          s_wait   = 0;
   int          s_linger = 0;
   logic        s_err    = 1'b0;
   logic [31:0] s_rdata  = 32'd0;
   int          acc_cnt  = 0;
   int          lg_cnt   = 0;
   logic        acc_rdy;

   assign acc_rdy             = bus.APB_M_0_psel && bus.APB_M_0_penable && (acc_cnt >= s_wait);
   assign bus.APB_M_0_pready  = acc_rdy || (lg_cnt != 0);
   assign bus.APB_M_0_pslverr = s_err;
   assign bus.APB_M_0_prdata  = s_rdata;

   always @(posedge clk) begin
      if (rst) begin
         acc_cnt <= 0;
         lg_cnt  <= 0;
      end else begin
         acc_cnt <= (bus.APB_M_0_psel && bus.APB_M_0_penable) ? acc_cnt + 1 : 0;
         if (acc_rdy) lg_cnt <= s_linger;
         else if (lg_cnt > 0) lg_cnt <= lg_cnt - 1;
      end
   end

   // Idle gap between the end of one transfer's psel and the start of the next.
   int   gap       = 0;
   logic psel_prev = 1'b0;
   logic seen_xfer = 1'b0;
   always @(negedge clk) begin
      if (bus.APB_M_0_psel && !psel_prev) begin
         if (seen_xfer) chk("psel_gap", 64'(gap >= 2), 64'd1);
         seen_xfer = 1'b1;
      end
      gap       = bus.APB_M_0_psel ? 0 : gap + 1;
      psel_prev = bus.APB_M_0_psel;
   end

   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input int wn, input logic er, input logic [31:0] rd,
                       input int lg, input int hold);
      logic        to;
      logic        eerr;
      logic [31:0] erd;
      int          lat, cnt, psel_n, pen_n, bad, guard;
      to   = (wn >= TMO);
      lat  = to ? TMO + 2 : 3 + wn;
      eerr = to | er;
      erd  = (to || wr) ? 32'd0 : rd;
      s_wait = wn; s_err = er; s_rdata = rd; s_linger = lg;
      bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wd;
      guard = 0;
      while (!bus.cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("cmd_accept", 64'(bus.cmd_ready), 64'd1);
      @(posedge clk);
      cnt = 0; psel_n = 0; pen_n = 0; bad = 0;
      do begin
         @(negedge clk);
         cnt++;
         if (cnt == 1) begin
            bus.cmd_valid = 1'b0; bus.cmd_write = ~wr;
            bus.cmd_addr = $urandom; bus.cmd_wdata = $urandom;
         end
         if (!bus.rsp_valid) begin
            if (bus.APB_M_0_psel) psel_n++;
            if (bus.APB_M_0_penable) pen_n++;
            if (bus.cmd_ready) bad++;
            if (bus.APB_M_0_psel && (bus.APB_M_0_paddr !== addr || bus.APB_M_0_pwdata !== wd
                                     || bus.APB_M_0_pwrite !== wr)) bad++;
         end
      end while (!bus.rsp_valid && cnt < 300);
      chk("latency", 64'(cnt), 64'(lat));
      chk("psel_cycles", 64'(psel_n), 64'(lat - 1));
      chk("penable_cycles", 64'(pen_n), 64'(lat - 2));
      chk("apb_stable", 64'(bad), 64'd0);
      chk("rsp_fields", {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, {eerr, to, erd});
      chk("resp_bus", {bus.APB_M_0_psel, bus.APB_M_0_penable, bus.cmd_ready, bus.APB_M_0_paddr},
          {3'b000, addr});
      if (hold > 0) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_addr  = $urandom;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold", {bus.rsp_valid, bus.cmd_ready, bus.APB_M_0_psel, bus.rsp_err, bus.rsp_timeout,
                      bus.rsp_rdata}, {3'b100, eerr, to, erd});
      end
      bus.rsp_ready = 1'b1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("rsp_done", {bus.rsp_valid, bus.cmd_ready}, 64'b01);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic reset_mid_access();
      logic seen;
      int   guard;
      s_wait = 255; s_linger = 0; s_err = 1'b0;
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
      bus.cmd_addr = 32'h40; bus.cmd_wdata = 32'h5555_AAAA;
      guard = 0;
      while (!bus.cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_access", {bus.APB_M_0_psel, bus.APB_M_0_penable}, 64'b11);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_mid", {bus.APB_M_0_psel, bus.APB_M_0_penable, bus.cmd_ready, bus.rsp_valid},
          64'b0010);
      chk("reset_mid_addr", 64'(bus.APB_M_0_paddr), 64'd0);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.rsp_valid || bus.APB_M_0_psel) seen = 1'b1;
      end
      chk("no_rsp_after_reset", 64'(seen), 64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'd0;
      bus.cmd_wdata = 32'd0; bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", {bus.cmd_ready, bus.rsp_valid, bus.APB_M_0_psel, bus.APB_M_0_penable,
                         bus.APB_M_0_pwrite, bus.rsp_err, bus.rsp_timeout}, 64'b1000000);
      chk("reset_data", {bus.APB_M_0_pwdata, bus.rsp_rdata}, 64'd0);
      chk("reset_addr", 64'(bus.APB_M_0_paddr), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      xfer(1'b1, 32'h08, 32'hA5A5_0001, 1, 1'b0, 32'hDEAD_BEEF, 1, 0);
      xfer(1'b0, 32'h0C, 32'h0, 0, 1'b0, 32'h1234_5678, 0, 0);
      xfer(1'b0, 32'h10, 32'h0, 255, 1'b0, 32'hFFFF_FFFF, 0, 0);
      xfer(1'b0, 32'h14, 32'h0, 15, 1'b0, 32'h0BAD_F00D, 0, 0);
      xfer(1'b1, 32'h18, 32'h7, 16, 1'b0, 32'h1111_2222, 0, 0);
      xfer(1'b0, 32'h1C, 32'h0, 0, 1'b1, 32'h3333_4444, 0, 5);
      reset_mid_access();
      xfer(1'b1, 32'h44, 32'hC0DE_0044, 1, 1'b0, 32'h0, 0, 0);
      xfer(1'b0, 32'h20, 32'h0, 1, 1'b0, 32'hCAFE_0001, 3, 0);
      xfer(1'b0, 32'h24, 32'h0, 2, 1'b0, 32'hCAFE_0002, 3, 0);

      for (int n = 0; n < 60; n++) begin
         int wn;
         wn = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 3));
         xfer(1'($urandom), $urandom, $urandom, wn, 1'($urandom), $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
